// File: rtl/bus_pkg.sv
// Shared state encoding, wait-counter sizing and control bundle for the AVR/SRAM bridge.
package bus_pkg;

  localparam logic [2:0] ST_IDLE      = 3'b000;
  localparam logic [2:0] ST_WR_SETUP  = 3'b001;
  localparam logic [2:0] ST_WR_STROBE = 3'b010;
  localparam logic [2:0] ST_WR_HOLD   = 3'b011;
  localparam logic [2:0] ST_RD_STROBE = 3'b100;
  localparam logic [2:0] ST_RD_DRIVE  = 3'b101;

  // Counter sized for the largest legal WAIT_CYCLES (15).
  localparam int CNT_W = $clog2(16);

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WR_SETUP  = ST_WR_SETUP,
    WR_STROBE = ST_WR_STROBE,
    WR_HOLD   = ST_WR_HOLD,
    RD_STROBE = ST_RD_STROBE,
    RD_DRIVE  = ST_RD_DRIVE
  } bus_state_e;

  typedef struct packed {
    logic sram_we_n;
    logic sram_oe_n;
    logic sram_en;
    logic avr_en;
  } bus_ctl_t;

  localparam bus_ctl_t CTL_IDLE = '{sram_we_n: 1'b1, sram_oe_n: 1'b1, sram_en: 1'b0, avr_en: 1'b0};

  function automatic logic [CNT_W-1:0] wait_load(input int unsigned wait_cycles);
    return CNT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// Multi-flop synchroniser for an asynchronous active-low strobe; idles (and resets) to 1.
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n,
  output logic strobe_s
);

  logic [SYNC_STAGES-1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (reset) sync_pipe <= '1;
    else       sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], strobe_n};
  end

  assign strobe_s = sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/sram_bus_bridge.sv
// Clocked AVR <-> SRAM bus bridge: synchronised strobes, holding register, programmable
// SRAM strobe width, registered strobes/enables, debug state/busy/err.
module sram_bus_bridge
  import bus_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_n,
  input  logic              oe_n,
  inout  wire  [DWIDTH-1:0] avr,
  inout  wire  [DWIDTH-1:0] sram,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              busy,
  output logic              err,
  output logic [2:0]        state_dbg
);

  localparam logic [CNT_W-1:0] WAIT_LD = wait_load(WAIT_CYCLES);

  logic we_s, oe_s;

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_we_sync (
    .clk(clk), .reset(reset), .strobe_n(we_n), .strobe_s(we_s)
  );

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_oe_sync (
    .clk(clk), .reset(reset), .strobe_n(oe_n), .strobe_s(oe_s)
  );

  bus_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DWIDTH-1:0] hold;
  bus_ctl_t          ctl;

  // Strobes and enables are flops that follow the state by one cycle: the first cycle
  // of each strobe state arms the SRAM strobe, and the counter runs while it is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      ctl   <= CTL_IDLE;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!we_s && !oe_s) begin
            err <= 1'b1;
          end else if (!we_s) begin
            hold  <= avr;
            busy  <= 1'b1;
            state <= WR_SETUP;
          end else if (!oe_s) begin
            cnt   <= WAIT_LD;
            busy  <= 1'b1;
            state <= RD_STROBE;
          end
        end
        WR_SETUP: begin
          ctl.sram_en <= 1'b1;
          cnt         <= WAIT_LD;
          state       <= WR_STROBE;
        end
        WR_STROBE: begin
          if (ctl.sram_we_n) begin
            ctl.sram_we_n <= 1'b0;
          end else if (cnt == '0) begin
            ctl.sram_we_n <= 1'b1;
            state         <= WR_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_HOLD: begin
          // Data stays on sram for at least one cycle past the rising write strobe.
          if (we_s) begin
            ctl.sram_en <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        RD_STROBE: begin
          if (ctl.sram_oe_n) begin
            ctl.sram_oe_n <= 1'b0;
          end else if (cnt == '0) begin
            ctl.sram_oe_n <= 1'b1;
            ctl.avr_en    <= 1'b1;
            hold          <= sram;
            state         <= RD_DRIVE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_DRIVE: begin
          if (oe_s) begin
            ctl.avr_en <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          ctl   <= CTL_IDLE;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign avr       = ctl.avr_en  ? hold : 'z;
  assign sram      = ctl.sram_en ? hold : 'z;
  assign sram_we_n = ctl.sram_we_n;
  assign sram_oe_n = ctl.sram_oe_n;
  assign state_dbg = state;

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Bench for sram_bus_bridge: three parameter sets run side by side, each checked cycle by
// cycle against timing windows derived from sync depth, wait count and strobe length.
module tb_sram_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input int inst, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL c%0d_%s got=%0h exp=%0h", inst, tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int DW = (g == 1) ? 16 : 8;
    localparam int WC = (g == 0) ? 1 : (g == 1) ? 2 : 3;
    localparam int SS = (g == 2) ? 3 : 2;
    localparam logic [DW-1:0] ONES = '1;

    logic reset, we_n, oe_n, sram_we_n, sram_oe_n, busy, err;
    logic [2:0] state_dbg;
    wire  [DW-1:0] avr, sram;
    logic [DW-1:0] avr_drv, mem, exp_mem;
    logic avr_drv_en, exp_err, fin;
    int wr_cnt = 0;

    // AVR data driver, SRAM device model, and pull-ups so a floating bus reads all ones.
    assign avr  = avr_drv_en ? avr_drv : 'z;
    assign sram = !sram_oe_n ? mem : 'z;
    pullup (avr);
    pullup (sram);

    always @(posedge sram_we_n) begin
      mem    <= sram;
      wr_cnt <= wr_cnt + 1;
    end

    sram_bus_bridge #(.DWIDTH(DW), .WAIT_CYCLES(WC), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset(reset), .we_n(we_n), .oe_n(oe_n), .avr(avr), .sram(sram),
      .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .busy(busy), .err(err),
      .state_dbg(state_dbg)
    );

    function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] v;
      v = DW'($urandom);
      if (&v) v[0] = 1'b0;
      return v;
    endfunction

    // Entered #1 after a rising edge (edge 0); strobe held for len cycles.
    task automatic do_write(input logic [DW-1:0] d, input int len);
      int x, c0, es;
      x  = max2(len + SS + 1, SS + 4 + WC);
      c0 = wr_cnt;
      we_n = 1'b0; avr_drv = d; avr_drv_en = 1'b1;
      for (int t = 0; t <= x; t++) begin
        if (t == len) begin we_n = 1'b1; avr_drv_en = 1'b0; end
        es = (t < SS + 1) ? 0 : (t == SS + 1) ? 1 : (t < SS + 3 + WC) ? 2 : (t < x) ? 3 : 0;
        @(negedge clk);
        chk(g, "wr_state", 32'(state_dbg), 32'(es));
        chk(g, "wr_busy", 32'(busy), 32'(t >= SS + 1 && t < x));
        chk(g, "wr_sram_we_n", 32'(sram_we_n), 32'(!(t >= SS + 3 && t < SS + 3 + WC)));
        chk(g, "wr_sram_oe_n", 32'(sram_oe_n), 32'd1);
        chk(g, "wr_sram_bus", 32'(sram), (t >= SS + 2 && t < x) ? 32'(d) : 32'(ONES));
        chk(g, "wr_avr_bus", 32'(avr), (t < len) ? 32'(d) : 32'(ONES));
        chk(g, "wr_err", 32'(err), 32'(exp_err));
        @(posedge clk); #1;
      end
      chk(g, "wr_count", 32'(wr_cnt - c0), 32'd1);
      chk(g, "wr_mem", 32'(mem), 32'(d));
      exp_mem = d;
    endtask

    task automatic do_read(input int len);
      int y, es;
      y = max2(len + SS + 1, SS + 3 + WC);
      oe_n = 1'b0;
      for (int t = 0; t <= y; t++) begin
        if (t == len) oe_n = 1'b1;
        es = (t < SS + 1) ? 0 : (t < SS + 2 + WC) ? 4 : (t < y) ? 5 : 0;
        @(negedge clk);
        chk(g, "rd_state", 32'(state_dbg), 32'(es));
        chk(g, "rd_busy", 32'(busy), 32'(t >= SS + 1 && t < y));
        chk(g, "rd_sram_oe_n", 32'(sram_oe_n), 32'(!(t >= SS + 2 && t < SS + 2 + WC)));
        chk(g, "rd_sram_we_n", 32'(sram_we_n), 32'd1);
        chk(g, "rd_sram_bus", 32'(sram), (t >= SS + 2 && t < SS + 2 + WC) ? 32'(exp_mem) : 32'(ONES));
        chk(g, "rd_avr_bus", 32'(avr), (t >= SS + 2 + WC && t < y) ? 32'(exp_mem) : 32'(ONES));
        chk(g, "rd_err", 32'(err), 32'(exp_err));
        @(posedge clk); #1;
      end
    endtask

    task automatic do_error(input int len);
      logic e0;
      e0 = exp_err;
      we_n = 1'b0; oe_n = 1'b0;
      for (int t = 0; t <= len + SS + 2; t++) begin
        if (t == len) begin we_n = 1'b1; oe_n = 1'b1; end
        @(negedge clk);
        chk(g, "er_state", 32'(state_dbg), 32'd0);
        chk(g, "er_busy", 32'(busy), 32'd0);
        chk(g, "er_strobes", 32'({sram_we_n, sram_oe_n}), 32'd3);
        chk(g, "er_sram_bus", 32'(sram), 32'(ONES));
        chk(g, "er_avr_bus", 32'(avr), 32'(ONES));
        chk(g, "er_err", 32'(err), 32'((t >= SS + 1) || e0));
        @(posedge clk); #1;
      end
      exp_err = 1'b1;
    endtask

    initial begin
      int len;
      fin = 1'b0; reset = 1'b1; we_n = 1'b1; oe_n = 1'b1;
      avr_drv = '0; avr_drv_en = 1'b0; exp_err = 1'b0; exp_mem = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(g, "rst_state", 32'(state_dbg), 32'd0);
      chk(g, "rst_busy", 32'(busy), 32'd0);
      chk(g, "rst_err", 32'(err), 32'd0);
      chk(g, "rst_strobes", 32'({sram_we_n, sram_oe_n}), 32'd3);
      chk(g, "rst_sram_bus", 32'(sram), 32'(ONES));
      chk(g, "rst_avr_bus", 32'(avr), 32'(ONES));
      @(posedge clk); #1;
      reset = 1'b0;

      do_write(DW'(32'hA5), 8);
      do_write(DW'(32'h3C), SS + 1);
      do_read(10);
      do_read(SS + 1);
      do_write(DW'(32'hBEEF), 5);
      do_read(5);

      for (int i = 0; i < 8; i++) begin
        len = int'($urandom_range(12, SS + 1));
        if ($urandom_range(1, 0) == 1) do_write(rnd_data(), len);
        else do_read(len);
      end

      do_error(4);
      do_write(rnd_data(), 6);
      do_read(6);

      // Reset while the SRAM write strobe is low.
      we_n = 1'b0; avr_drv = rnd_data(); avr_drv_en = 1'b1;
      repeat (SS + 3) begin @(posedge clk); #1; end
      @(negedge clk);
      chk(g, "pre_rst_state", 32'(state_dbg), 32'd2);
      chk(g, "pre_rst_we_n", 32'(sram_we_n), 32'd0);
      reset = 1'b1; we_n = 1'b1; avr_drv_en = 1'b0;
      @(negedge clk);
      chk(g, "mid_rst_state", 32'(state_dbg), 32'd0);
      chk(g, "mid_rst_busy", 32'(busy), 32'd0);
      chk(g, "mid_rst_we_n", 32'(sram_we_n), 32'd1);
      chk(g, "mid_rst_sram_bus", 32'(sram), 32'(ONES));
      chk(g, "mid_rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; exp_err = 1'b0;

      do_write(rnd_data(), 7);
      do_read(SS + 2);
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (cfg[0].fin && cfg[1].fin && cfg[2].fin);
      #500000;
    join_any
    disable fork;
    chk(9, "all_done", 32'(cfg[0].fin && cfg[1].fin && cfg[2].fin), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
